// File: rtl/axis_rx_mmio_bridge_pkg.sv
// Shared types for the MMIO Rx bridge: request header view, read-tag sideband record, FSM states.
// The sideband record is the same layout the Tx-side tag tracker stores per outstanding read.
package axis_rx_mmio_bridge_pkg;

    localparam int AXIS_DATA_W = 512;
    localparam int MMIO_MAX_DW = 2;

    localparam logic [7:0] FMT_MRD3 = 8'h00;
    localparam logic [7:0] FMT_MRD4 = 8'h20;
    localparam logic [7:0] FMT_MWR3 = 8'h40;
    localparam logic [7:0] FMT_MWR4 = 8'h60;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_e;

    typedef struct packed {
        logic [9:0]  tag;
        logic [13:0] length;
        logic [15:0] req_id;
        logic [23:0] low_addr;
    } rd_sideband_t;

    typedef struct packed {
        logic [7:0]  fmt_type;
        logic [9:0]  length_dw;
        logic [9:0]  tag;
        logic [15:0] req_id;
        logic [63:0] addr;
    } req_hdr_t;

    // A single-DW access lands in the lane selected by addr[2]; the data is mirrored so either lane is valid.
    function automatic logic [7:0] mmio_be(input logic addr2, input logic two_dw);
        return two_dw ? 8'hFF : (addr2 ? 8'hF0 : 8'h0F);
    endfunction

    function automatic logic [63:0] mmio_wdata(input logic [63:0] pl, input logic two_dw);
        return two_dw ? pl : {pl[31:0], pl[31:0]};
    endfunction

endpackage

// File: rtl/axis_rx_mmio_bridge_if.sv
// AXI-S TLP stream: header in tdata[255:0], payload in tdata[511:256], single valid/ready handshake.
interface axis_rx_mmio_bridge_if;
    logic         tvalid;
    logic         tready;
    logic         tlast;
    logic [511:0] tdata;

    modport master (output tvalid, tlast, tdata, input tready);
    modport slave  (input tvalid, tlast, tdata, output tready);
endinterface

// File: rtl/axis_rx_mmio_bridge_pipe.sv
// Input register slice on the Rx stream: 1 cycle latency, full throughput when downstream is ready.
// Backpressure: upstream ready drops while the slice is full and unconsumed, while hold_i is set, and during reset.
module axis_rx_mmio_bridge_pipe (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold_i,
    axis_rx_mmio_bridge_if.slave  in_if,
    axis_rx_mmio_bridge_if.master out_if
);

    logic         vld_q;
    logic         last_q;
    logic         init_q;
    logic [511:0] dat_q;

    assign in_if.tready  = init_q & ~hold_i & (~vld_q | out_if.tready);
    assign out_if.tvalid = vld_q;
    assign out_if.tlast  = last_q;
    assign out_if.tdata  = dat_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            init_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            init_q <= 1'b1;
            if (in_if.tvalid && in_if.tready) begin
                vld_q  <= 1'b1;
                last_q <= in_if.tlast;
                dat_q  <= in_if.tdata;
            end else if (out_if.tready) begin
                vld_q  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axis_rx_mmio_bridge.sv
// Turns single-beat MRd/MWr TLPs into one AVMM command each; command appears 1 cycle after header decode.
// Backpressure: stream stalls while a command waits on waitrequest, and while a head MRd is blocked by count/almfull.
module axis_rx_mmio_bridge
    import axis_rx_mmio_bridge_pkg::*;
#(
    parameter int AVMM_ADDR_WIDTH = 20,
    parameter int AVMM_DATA_WIDTH = 64,
    parameter int MAX_RD_OUTSTAND = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    axis_rx_mmio_bridge_if.slave         axis_rx_if,
    output logic                         rx_error,
    input  logic                         tx_almfull,
    output logic [AVMM_ADDR_WIDTH-1:0]   avmm_m2s_address,
    output logic                         avmm_m2s_read,
    output logic                         avmm_m2s_write,
    output logic [AVMM_DATA_WIDTH-1:0]   avmm_m2s_writedata,
    output logic [AVMM_DATA_WIDTH/8-1:0] avmm_m2s_byteenable,
    input  logic                         avmm_s2m_waitrequest,
    input  logic                         avmm_s2m_readdatavalid,
    output logic                         tlp_rd_strb,
    output logic [9:0]                   tlp_rd_tag,
    output logic [13:0]                  tlp_rd_length,
    output logic [15:0]                  tlp_rd_req_id,
    output logic [23:0]                  tlp_rd_low_addr
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_RD_OUTSTAND);

    axis_rx_mmio_bridge_if rx_q_if ();

    fsm_e                         state_q;
    logic                         rd_q, wr_q, err_q;
    logic [AVMM_ADDR_WIDTH-1:0]   addr_q;
    logic [AVMM_DATA_WIDTH-1:0]   wdata_q;
    logic [AVMM_DATA_WIDTH/8-1:0] be_q;
    rd_sideband_t                 sb_q;
    logic [7:0]                   rd_cnt_q, rd_cnt_d;
    logic                         rd_inc, rd_dec;

    logic [255:0] hdr_dat;
    logic [63:0]  pl_dat;
    req_hdr_t     hdr;
    logic         is_mrd, is_mwr, two_dw, len_ok, align_ok, rd_block, supported, beat_acc;
    logic         in_hold;
    logic         unused_dat;

    assign in_hold = (state_q == ST_CMD);

    axis_rx_mmio_bridge_pipe u_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold_i (in_hold),
        .in_if  (axis_rx_if),
        .out_if (rx_q_if)
    );

    assign hdr_dat = rx_q_if.tdata[255:0];
    assign pl_dat  = rx_q_if.tdata[319:256];

    // Tag bits 9/8 sit in the DW0 T9/T8 positions; fmt_type[5] selects the 4DW (64-bit address) layout.
    always_comb begin
        hdr           = '0;
        hdr.fmt_type  = hdr_dat[31:24];
        hdr.length_dw = hdr_dat[9:0];
        hdr.tag       = {hdr_dat[23], hdr_dat[19], hdr_dat[47:40]};
        hdr.req_id    = hdr_dat[63:48];
        hdr.addr      = hdr_dat[29] ? {hdr_dat[95:64], hdr_dat[127:98], 2'b00}
                                    : {32'h0, hdr_dat[95:66], 2'b00};
    end

    assign unused_dat = ^{hdr_dat[255:128], hdr_dat[97:96], hdr_dat[39:32], hdr_dat[22:20],
                          hdr_dat[18:10], rx_q_if.tdata[511:320], hdr.addr[63:24]};

    assign is_mrd    = (hdr.fmt_type == FMT_MRD3) || (hdr.fmt_type == FMT_MRD4);
    assign is_mwr    = (hdr.fmt_type == FMT_MWR3) || (hdr.fmt_type == FMT_MWR4);
    assign two_dw    = (hdr.length_dw == 10'(MMIO_MAX_DW));
    assign len_ok    = (hdr.length_dw == 10'd1) || two_dw;
    assign align_ok  = !(two_dw && hdr.addr[2]);
    assign rd_block  = (rd_cnt_q >= MAX_CNT) || tx_almfull;
    assign supported = (is_mwr || (is_mrd && !rd_block)) && len_ok && align_ok && rx_q_if.tlast;

    assign rx_q_if.tready = ((state_q == ST_IDLE) && !(is_mrd && rd_block)) || (state_q == ST_DRAIN);
    assign beat_acc       = rx_q_if.tvalid && rx_q_if.tready;

    assign rd_inc = rd_q && !avmm_s2m_waitrequest;
    assign rd_dec = avmm_s2m_readdatavalid && (rd_cnt_q != 8'd0);

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (rd_inc && !rd_dec && (rd_cnt_q < MAX_CNT)) begin
            rd_cnt_d = rd_cnt_q + 8'd1;
        end else if (!rd_inc && rd_dec) begin
            rd_cnt_d = rd_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            sb_q     <= '0;
            rd_cnt_q <= '0;
        end else begin
            err_q    <= 1'b0;
            rd_cnt_q <= rd_cnt_d;
            case (state_q)
                ST_IDLE: begin
                    if (beat_acc) begin
                        if (supported) begin
                            state_q <= ST_CMD;
                            rd_q    <= is_mrd;
                            wr_q    <= is_mwr;
                            addr_q  <= {hdr.addr[AVMM_ADDR_WIDTH-1:3], 3'b000};
                            be_q    <= mmio_be(hdr.addr[2], two_dw);
                            wdata_q <= mmio_wdata(pl_dat, two_dw);
                            if (is_mrd) begin
                                sb_q <= '{tag: hdr.tag, length: (two_dw ? 14'd8 : 14'd4),
                                          req_id: hdr.req_id, low_addr: hdr.addr[23:0]};
                            end
                        end else begin
                            err_q <= 1'b1;
                            if (!rx_q_if.tlast) begin
                                state_q <= ST_DRAIN;
                            end
                        end
                    end
                end
                ST_CMD: begin
                    if (!avmm_s2m_waitrequest) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (beat_acc && rx_q_if.tlast) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rx_error            = err_q;
    assign avmm_m2s_read       = rd_q;
    assign avmm_m2s_write      = wr_q;
    assign avmm_m2s_address    = addr_q;
    assign avmm_m2s_writedata  = wdata_q;
    assign avmm_m2s_byteenable = be_q;
    assign tlp_rd_strb         = rd_inc;
    assign tlp_rd_tag          = sb_q.tag;
    assign tlp_rd_length       = sb_q.length;
    assign tlp_rd_req_id       = sb_q.req_id;
    assign tlp_rd_low_addr     = sb_q.low_addr;

    // A read return with nothing outstanding means the slave and this bridge disagree about in-flight reads.
    a_no_dec_at_zero: assert property (@(posedge clk) disable iff (!rst_n)
        !(avmm_s2m_readdatavalid && (rd_cnt_q == 8'd0)));

endmodule
